// File: rtl/i2c_eeprom_arbiter.sv
// rtl/i2c_eeprom_arbiter.sv - two-client round-robin arbiter/sequencer for the I2C EEPROM master
//
// Purpose: grants byte-write and random-read transactions from two clients
// round-robin, holds the master's level-sensitive request/address/data inputs
// steady for the whole transfer, returns completion and read data to the
// winning client and enforces the EEPROM internal write-cycle gap after writes.
// Optional feature macro: I2C_ARB_TIMEOUT_EN (abort a transfer that sees no
// master ack within TIMEOUT_CYCLES; otherwise BUSY waits indefinitely).
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cN_req/wr/dev/reg/wdata          client N request (level, held until cN_ack)
//   cN_ack/rdata/err                 client N completion pulse, read data, timeout flag
//   mst_write_req/mst_read_req       level requests to the I2C master
//   mst_wr_dev_addr/wr_reg_addr/wdata    write address/data held for the master
//   mst_rd_dev_addr/rd_reg_addr      read address held for the master
//   mst_ack, mst_rdata               master completion pulse and read data
//   mst_abort                        one-cycle master reset request on timeout
module i2c_eeprom_arbiter #(
   parameter int WR_GAP_CYCLES  = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       c0_req,
   input  logic       c0_wr,
   input  logic [6:0] c0_dev,
   input  logic [7:0] c0_reg,
   input  logic [7:0] c0_wdata,
   output logic       c0_ack,
   output logic [7:0] c0_rdata,
   output logic       c0_err,
   input  logic       c1_req,
   input  logic       c1_wr,
   input  logic [6:0] c1_dev,
   input  logic [7:0] c1_reg,
   input  logic [7:0] c1_wdata,
   output logic       c1_ack,
   output logic [7:0] c1_rdata,
   output logic       c1_err,
   output logic       mst_write_req,
   output logic       mst_read_req,
   output logic [7:0] mst_wr_dev_addr,
   output logic [7:0] mst_wr_reg_addr,
   output logic [7:0] mst_wdata,
   output logic [7:0] mst_rd_dev_addr,
   output logic [7:0] mst_rd_reg_addr,
   input  logic       mst_ack,
   input  logic [7:0] mst_rdata,
   output logic       mst_abort
);

   localparam int GAP_W = (WR_GAP_CYCLES > 0) ? $clog2(WR_GAP_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((WR_GAP_CYCLES > 0) ? WR_GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

   state_t           state_q;
   logic             last_grant_q;
   logic             grant_q;
   logic             op_wr_q;
   logic [GAP_W-1:0] gap_cnt_q;

   logic       c0_ack_q, c1_ack_q;
   logic [7:0] c0_rdata_q, c1_rdata_q;
   logic       mst_write_req_q, mst_read_req_q;
   logic [7:0] mst_wr_dev_addr_q, mst_wr_reg_addr_q, mst_wdata_q;
   logic [7:0] mst_rd_dev_addr_q, mst_rd_reg_addr_q;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             mst_abort_q, c0_err_q, c1_err_q;
`endif

   logic       elig0_d, elig1_d, grant_valid_d, grant_sel_d, sel_wr_d;
   logic [6:0] sel_dev_d;
   logic [7:0] sel_reg_d, sel_wdata_d;

   always_comb begin
      // A client whose ack is high this cycle is still dropping req; skip it.
      elig0_d       = c0_req & ~c0_ack_q;
      elig1_d       = c1_req & ~c1_ack_q;
      grant_valid_d = elig0_d | elig1_d;
      // On a tie the client that did not win last time goes next.
      grant_sel_d   = (elig0_d & elig1_d) ? ~last_grant_q : elig1_d;
      sel_wr_d      = grant_sel_d ? c1_wr    : c0_wr;
      sel_dev_d     = grant_sel_d ? c1_dev   : c0_dev;
      sel_reg_d     = grant_sel_d ? c1_reg   : c0_reg;
      sel_wdata_d   = grant_sel_d ? c1_wdata : c0_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         last_grant_q      <= 1'b1;
         grant_q           <= 1'b0;
         op_wr_q           <= 1'b0;
         gap_cnt_q         <= '0;
         c0_ack_q          <= 1'b0;
         c1_ack_q          <= 1'b0;
         c0_rdata_q        <= 8'hFF;
         c1_rdata_q        <= 8'hFF;
         mst_write_req_q   <= 1'b0;
         mst_read_req_q    <= 1'b0;
         mst_wr_dev_addr_q <= 8'h00;
         mst_wr_reg_addr_q <= 8'h00;
         mst_wdata_q       <= 8'h00;
         mst_rd_dev_addr_q <= 8'h00;
         mst_rd_reg_addr_q <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
         tmo_cnt_q         <= '0;
         mst_abort_q       <= 1'b0;
         c0_err_q          <= 1'b0;
         c1_err_q          <= 1'b0;
`endif
      end else begin
         c0_ack_q <= 1'b0;
         c1_ack_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         mst_abort_q <= 1'b0;
         c0_err_q    <= 1'b0;
         c1_err_q    <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (grant_valid_d) begin
                  last_grant_q <= grant_sel_d;
                  grant_q      <= grant_sel_d;
                  op_wr_q      <= sel_wr_d;
                  // Only the fields of the chosen op change; the others keep their value.
                  if (sel_wr_d) begin
                     mst_write_req_q   <= 1'b1;
                     mst_wr_dev_addr_q <= {sel_dev_d, 1'b0};
                     mst_wr_reg_addr_q <= sel_reg_d;
                     mst_wdata_q       <= sel_wdata_d;
                  end else begin
                     mst_read_req_q    <= 1'b1;
                     mst_rd_dev_addr_q <= {sel_dev_d, 1'b1};
                     mst_rd_reg_addr_q <= sel_reg_d;
                  end
`ifdef I2C_ARB_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // The ack is checked first so it wins over a same-cycle timeout.
               if (mst_ack) begin
                  mst_write_req_q <= 1'b0;
                  mst_read_req_q  <= 1'b0;
                  if (grant_q) begin
                     c1_ack_q <= 1'b1;
                     if (!op_wr_q) c1_rdata_q <= mst_rdata;
                  end else begin
                     c0_ack_q <= 1'b1;
                     if (!op_wr_q) c0_rdata_q <= mst_rdata;
                  end
                  gap_cnt_q <= '0;
                  state_q   <= (op_wr_q && (WR_GAP_CYCLES > 0)) ? ST_GAP : ST_IDLE;
               end
`ifdef I2C_ARB_TIMEOUT_EN
               else if (tmo_cnt_q == TMO_LAST) begin
                  mst_write_req_q <= 1'b0;
                  mst_read_req_q  <= 1'b0;
                  mst_abort_q     <= 1'b1;
                  if (grant_q) begin
                     c1_ack_q   <= 1'b1;
                     c1_err_q   <= 1'b1;
                     c1_rdata_q <= 8'hFF;
                  end else begin
                     c0_ack_q   <= 1'b1;
                     c0_err_q   <= 1'b1;
                     c0_rdata_q <= 8'hFF;
                  end
                  state_q <= ST_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) state_q <= ST_IDLE;
               else gap_cnt_q <= gap_cnt_q + 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign c0_ack          = c0_ack_q;
   assign c1_ack          = c1_ack_q;
   assign c0_rdata        = c0_rdata_q;
   assign c1_rdata        = c1_rdata_q;
   assign mst_write_req   = mst_write_req_q;
   assign mst_read_req    = mst_read_req_q;
   assign mst_wr_dev_addr = mst_wr_dev_addr_q;
   assign mst_wr_reg_addr = mst_wr_reg_addr_q;
   assign mst_wdata       = mst_wdata_q;
   assign mst_rd_dev_addr = mst_rd_dev_addr_q;
   assign mst_rd_reg_addr = mst_rd_reg_addr_q;

`ifdef I2C_ARB_TIMEOUT_EN
   assign mst_abort = mst_abort_q;
   assign c0_err    = c0_err_q;
   assign c1_err    = c1_err_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign mst_abort  = 1'b0;
   assign c0_err     = 1'b0;
   assign c1_err     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// tb/tb_i2c_eeprom_arbiter.sv - self-checking bench for i2c_eeprom_arbiter
module tb_i2c_eeprom_arbiter;

   localparam int GAP = 8;
   localparam int TMO = 50;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [1:0] req_v, wr_v;
   logic [6:0] dev_v [2];
   logic [7:0] reg_v [2];
   logic [7:0] wd_v  [2];
   logic       mack_v;
   logic [7:0] mrd_v;

   logic       c0_ack, c0_err, c1_ack, c1_err;
   logic [7:0] c0_rdata, c1_rdata;
   logic       mst_write_req, mst_read_req, mst_abort;
   logic [7:0] mst_wr_dev_addr, mst_wr_reg_addr, mst_wdata, mst_rd_dev_addr, mst_rd_reg_addr;

   i2c_eeprom_arbiter #(.WR_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .c0_req(req_v[0]), .c0_wr(wr_v[0]), .c0_dev(dev_v[0]), .c0_reg(reg_v[0]), .c0_wdata(wd_v[0]),
      .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
      .c1_req(req_v[1]), .c1_wr(wr_v[1]), .c1_dev(dev_v[1]), .c1_reg(reg_v[1]), .c1_wdata(wd_v[1]),
      .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
      .mst_write_req(mst_write_req), .mst_read_req(mst_read_req),
      .mst_wr_dev_addr(mst_wr_dev_addr), .mst_wr_reg_addr(mst_wr_reg_addr), .mst_wdata(mst_wdata),
      .mst_rd_dev_addr(mst_rd_dev_addr), .mst_rd_reg_addr(mst_rd_reg_addr),
      .mst_ack(mack_v), .mst_rdata(mrd_v), .mst_abort(mst_abort)
   );

   // Reference model: transaction-level arbiter state plus expected outputs.
   int         k = 0;
   bit         m_busy = 0;
   int         m_cli = 0;
   bit         m_wr = 0;
   int         m_free = 0;
   int         m_last = 1;
   int         m_gedge = 0;
   bit         just_granted = 0;
   logic       e_wreq = 0, e_rreq = 0, e_abort = 0;
   logic [1:0] e_ack = 0, e_err = 0;
   logic [7:0] e_rdata [2];
   logic [7:0] e_wr_dev, e_wr_reg, e_wdata, e_rd_dev, e_rd_reg;

   bit         auto_mode = 0, m_never = 0, force_rd = 0;
   int         force_delay = -1;
   int         mcnt = 0;
   logic [7:0] rd_val = 8'h00;
   bit         hold_x [2];

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_edge();
      logic [1:0] prev_ack, elig;
      int sel;
      prev_ack = e_ack;
      e_ack = 2'b00; e_err = 2'b00; e_abort = 1'b0;
      if (reset) begin
         m_busy = 0; m_last = 1; m_free = 0;
         e_wreq = 0; e_rreq = 0;
         e_rdata[0] = 8'hFF; e_rdata[1] = 8'hFF;
         e_wr_dev = 0; e_wr_reg = 0; e_wdata = 0; e_rd_dev = 0; e_rd_reg = 0;
      end else if (m_busy) begin
         if (mack_v) begin
            e_wreq = 0; e_rreq = 0;
            e_ack[m_cli] = 1'b1;
            if (!m_wr) e_rdata[m_cli] = mrd_v;
            m_busy = 0;
            // Writes leave GAP idle cycles before the next possible grant edge.
            m_free = (m_wr && GAP > 0) ? k + GAP + 1 : k + 1;
         end
`ifdef I2C_ARB_TIMEOUT_EN
         else if (k - m_gedge == TMO) begin
            e_wreq = 0; e_rreq = 0; e_abort = 1;
            e_ack[m_cli] = 1'b1; e_err[m_cli] = 1'b1; e_rdata[m_cli] = 8'hFF;
            m_busy = 0; m_free = k + 1;
         end
`endif
      end else if (k >= m_free) begin
         elig = req_v & ~prev_ack;
         if (elig != 2'b00) begin
            sel = (elig == 2'b11) ? 1 - m_last : (elig[1] ? 1 : 0);
            m_busy = 1; m_cli = sel; m_last = sel; m_wr = wr_v[sel]; m_gedge = k;
            just_granted = 1;
            if (m_wr) begin
               e_wreq = 1; e_wr_dev = {dev_v[sel], 1'b0}; e_wr_reg = reg_v[sel]; e_wdata = wd_v[sel];
            end else begin
               e_rreq = 1; e_rd_dev = {dev_v[sel], 1'b1}; e_rd_reg = reg_v[sel];
            end
         end
      end
   endtask

   task automatic compare_all();
      check("mst_req",  32'({mst_write_req, mst_read_req}), 32'({e_wreq, e_rreq}));
      check("c_ack",    32'({c1_ack, c0_ack}), 32'(e_ack));
      check("c_err",    32'({c1_err, c0_err}), 32'(e_err));
      check("abort",    32'(mst_abort), 32'(e_abort));
      check("c0_rdata", 32'(c0_rdata), 32'(e_rdata[0]));
      check("c1_rdata", 32'(c1_rdata), 32'(e_rdata[1]));
      check("wr_fields", 32'({mst_wr_dev_addr, mst_wr_reg_addr, mst_wdata}), 32'({e_wr_dev, e_wr_reg, e_wdata}));
      check("rd_fields", 32'({mst_rd_dev_addr, mst_rd_reg_addr}), 32'({e_rd_dev, e_rd_reg}));
   endtask

   task automatic drive_master();
      if (just_granted) mcnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 5));
      mack_v = 1'b0;
      mrd_v  = 8'($urandom);
      if (m_busy && !m_never) begin
         if (mcnt == 0) begin
            mack_v = 1'b1;
            if (force_rd) mrd_v = rd_val;
         end else mcnt--;
      end
   endtask

   task automatic rand_fields(input int i);
      wr_v[i]  = 1'($urandom_range(0, 1));
      dev_v[i] = 7'($urandom);
      reg_v[i] = 8'($urandom);
      wd_v[i]  = 8'($urandom);
   endtask

   task automatic drive_clients();
      for (int i = 0; i < 2; i++) begin
         if (e_ack[i]) begin
            if ($urandom_range(0, 2) == 0) hold_x[i] = 1;
            else req_v[i] = 1'b0;
         end else if (hold_x[i]) begin
            hold_x[i] = 0;
            req_v[i] = 1'b0;
         end else if (m_busy && m_cli == i) begin
            if ($urandom_range(0, 3) == 0) rand_fields(i);
            if ($urandom_range(0, 9) == 0) req_v[i] = 1'b0;
         end else if (req_v[i]) begin
            if ($urandom_range(0, 39) == 0) req_v[i] = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            req_v[i] = 1'b1;
            rand_fields(i);
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      k++;
      just_granted = 0;
      model_edge();
      compare_all();
      drive_master();
      if (auto_mode) drive_clients();
   endtask

   task automatic set_req(input int c, input logic w, input logic [6:0] d, input logic [7:0] r, input logic [7:0] wd);
      req_v[c] = 1'b1; wr_v[c] = w; dev_v[c] = d; reg_v[c] = r; wd_v[c] = wd;
   endtask

   task automatic wait_ack(input int c, input int budget, input string tag);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(c == 1 ? c1_ack : c0_ack) && n < budget);
      check({tag, "_ack"}, 32'(c == 1 ? c1_ack : c0_ack), 32'd1);
   endtask

   initial begin
      int n, cnt;
      logic [3:0] seq;
      reset = 1'b1; req_v = 2'b00; wr_v = 2'b00; mack_v = 1'b0; mrd_v = 8'h00;
      hold_x[0] = 0; hold_x[1] = 0;
      for (int i = 0; i < 2; i++) begin
         dev_v[i] = 0; reg_v[i] = 0; wd_v[i] = 0; e_rdata[i] = 8'hFF;
      end
      e_wr_dev = 0; e_wr_reg = 0; e_wdata = 0; e_rd_dev = 0; e_rd_reg = 0;
      repeat (3) cycle();
      check("rst_c0_rdata", 32'(c0_rdata), 32'hFF);
      check("rst_req", 32'({mst_write_req, mst_read_req}), 32'd0);
      reset = 1'b0;

      // c0 byte write
      set_req(0, 1'b1, 7'h50, 8'h10, 8'hA5);
      cycle();
      check("t1_wreq", 32'(mst_write_req), 32'd1);
      check("t1_wr_dev", 32'(mst_wr_dev_addr), 32'hA0);
      check("t1_wr_reg", 32'(mst_wr_reg_addr), 32'h10);
      check("t1_wdata", 32'(mst_wdata), 32'hA5);
      wait_ack(0, 20, "t1");
      check("t1_err", 32'(c0_err), 32'd0);
      req_v[0] = 1'b0;

      // c1 read arriving during the write gap: granted exactly when the gap ends
      set_req(1, 1'b0, 7'h50, 8'h22, 8'h00);
      force_rd = 1; rd_val = 8'h3C;
      n = 0;
      while (!mst_read_req && n < GAP + 10) begin
         cycle();
         n++;
      end
      check("t2_gap_len", 32'(n), 32'(GAP + 1));
      check("t2_rd_dev", 32'(mst_rd_dev_addr), 32'hA1);
      check("t2_wr_dev", 32'(mst_wr_dev_addr), 32'hA0);
      check("t2_rd_reg", 32'(mst_rd_reg_addr), 32'h22);
      wait_ack(1, 20, "t2");
      check("t2_rdata", 32'(c1_rdata), 32'h3C);
      force_rd = 0;
      req_v[1] = 1'b0;
      cycle();

      // both clients request in the same cycle and hold
      set_req(0, 1'b0, 7'h11, 8'h01, 8'h00);
      set_req(1, 1'b0, 7'h22, 8'h02, 8'h00);
      seq = 4'b0000; cnt = 0; n = 0;
      while (cnt < 4 && n < 200) begin
         cycle();
         n++;
         if (c0_ack || c1_ack) begin
            seq = {seq[2:0], c1_ack};
            cnt++;
         end
      end
      check("tie_cnt", 32'(cnt), 32'd4);
      check("tie_order", 32'(seq), 32'b0101);
      req_v = 2'b00;
      repeat (2) cycle();

      // c0 holds req one cycle past its ack: no re-grant that cycle
      set_req(0, 1'b0, 7'h33, 8'h44, 8'h00);
      wait_ack(0, 20, "t4");
      cycle();
      check("t4_no_regrant", 32'({mst_write_req, mst_read_req}), 32'd0);
      req_v[0] = 1'b0;
      cycle();

      // reset while BUSY
      set_req(0, 1'b1, 7'h50, 8'h77, 8'h5A);
      m_never = 1;
      repeat (3) cycle();
      check("t5_busy", 32'(mst_write_req), 32'd1);
      reset = 1'b1;
      cycle();
      check("t5_req_drop", 32'(mst_write_req), 32'd0);
      check("t5_no_ack", 32'(c0_ack), 32'd0);
      reset = 1'b0;
      req_v[0] = 1'b0;
      m_never = 0;
      repeat (4) cycle();

`ifdef I2C_ARB_TIMEOUT_EN
      // master never acks: abort after TMO cycles
      set_req(0, 1'b0, 7'h51, 8'h33, 8'h00);
      m_never = 1;
      cycle();
      check("t6_rreq", 32'(mst_read_req), 32'd1);
      n = 0;
      while (!mst_abort && n < TMO + 10) begin
         cycle();
         n++;
      end
      check("t6_abort_at", 32'(n), 32'(TMO));
      check("t6_ack", 32'(c0_ack), 32'd1);
      check("t6_err", 32'(c0_err), 32'd1);
      check("t6_rdata", 32'(c0_rdata), 32'hFF);
      m_never = 0;
      req_v[0] = 1'b0;
      cycle();

      // ack on the timeout cycle wins
      set_req(0, 1'b0, 7'h51, 8'h34, 8'h00);
      force_delay = TMO - 1; force_rd = 1; rd_val = 8'h5A;
      wait_ack(0, TMO + 10, "t7");
      check("t7_err", 32'(c0_err), 32'd0);
      check("t7_rdata", 32'(c0_rdata), 32'h5A);
      check("t7_abort", 32'(mst_abort), 32'd0);
      force_delay = -1; force_rd = 0;
      req_v[0] = 1'b0;
      cycle();
`endif

      // randomized traffic
      auto_mode = 1;
      repeat (3000) cycle();
      auto_mode = 0;
      req_v = 2'b00;
      hold_x[0] = 0; hold_x[1] = 0;
      repeat (40) cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/i2c_eeprom_arbiter.md
Name: i2c_eeprom_arbiter

Overview:
Two-client arbiter and sequencer in front of the I2C EEPROM master. It accepts byte-write and random-read transactions from two independent requesters and grants them round-robin. It drives the master's level-sensitive req/address/data inputs and holds them stable for the whole transfer. It returns read data and completion pulses to the winning client, and enforces the EEPROM internal write-cycle gap after every write.

Parameters:
WR_GAP_CYCLES, 5000, idle clk cycles enforced after a write completes before the next grant; 0 = no gap
TIMEOUT_CYCLES, 100000, max clk cycles in BUSY before abort; used only with I2C_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
c0_req  in  1  client 0 request, level; held until c0_ack
c0_wr  in  1  1 = byte write, 0 = random read
c0_dev  in  7  7-bit device address
c0_reg  in  8  register/word address
c0_wdata  in  8  write data
c0_ack  out  1  one-cycle completion pulse
c0_rdata  out  8  read data, valid while c0_ack=1
c0_err  out  1  timeout flag, valid while c0_ack=1
c1_req, c1_wr, c1_dev, c1_reg, c1_wdata, c1_ack, c1_rdata, c1_err: same as client 0
mst_write_req  out  1  to master i2c_write_req
mst_read_req  out  1  to master i2c_read_req
mst_wr_dev_addr  out  8  {dev,1'b0}
mst_wr_reg_addr  out  8  reg (write)
mst_wdata  out  8  write data
mst_rd_dev_addr  out  8  {dev,1'b1}
mst_rd_reg_addr  out  8  reg (read)
mst_ack  in  1  master write/read ack (one-cycle pulse)
mst_rdata  in  8  master read data, valid at mst_ack
mst_abort  out  1  one-cycle pulse requesting master reset (timeout only)

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, on the port reset.
- All outputs are registered. Reset values: every req/ack/err/abort = 0; all address/data outputs = 0; c*_rdata = 8'hFF.
- Internal reset state: state=IDLE, last_grant=1, so client 0 wins the first tie.
- Reset mid-transfer: master req drops on the next edge; no client ack is issued.
- States:
  - IDLE: evaluate eligible requests. A client is eligible if c*_req=1 and its c*_ack is not asserted this cycle. This blocks a re-grant on the cycle after ack, while the client is still dropping req.
  - Single eligible client wins. Both eligible: the client != last_grant wins.
  - On grant, in the same edge: latch wr/dev/reg/wdata; drive mst_* address/data; assert exactly one of mst_write_req or mst_read_req; set last_grant; go to BUSY.
  - Latency: req sampled at cycle n → mst_*_req high at n+1.
  - BUSY: hold the mst_* outputs constant. Clients may change their inputs once granted.
  - On mst_ack=1: drop mst_*_req; pulse the granted c*_ack; load c*_rdata=mst_rdata for reads. Writes leave c*_rdata unchanged. c*_err=0.
  - After ack: go to GAP if the op was a write and WR_GAP_CYCLES>0, else IDLE.
  - GAP: count WR_GAP_CYCLES cycles, then IDLE. Requests arriving in GAP wait; no grant occurs during GAP.
- Client ack lags mst_ack by one cycle.
- Unused mst address fields for the current op hold their previous value.
- A client that drops req before grant is never serviced. Dropping req while BUSY does not abort the transfer; the ack is still pulsed.
- Gap counter width: ceil(log2(WR_GAP_CYCLES+1)), minimum 1.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - BUSY counts cycles since grant. On reaching TIMEOUT_CYCLES without mst_ack: drop mst_*_req, pulse mst_abort for 1 cycle, pulse c*_ack with c*_err=1 and c*_rdata=8'hFF, go to IDLE. No gap after a timeout.
  - mst_ack in the same cycle as the timeout hit: the ack wins, and the response is normal.
- Not defined: no counter; BUSY waits indefinitely; mst_abort and c*_err tied 0.

Test Plan:
- Reset, then c0 write dev=7'h50 reg=8'h10 data=8'hA5 → next cycle mst_write_req=1, mst_wr_dev_addr=8'hA0, wr_reg=8'h10, wdata=8'hA5. mst_ack pulse → c0_ack 1 cycle later, c0_err=0. Then WR_GAP_CYCLES of GAP.
- c1 read dev=7'h50 reg=8'h22, master returns 8'h3C → mst_read_req=1, mst_wr_dev_addr=8'hA0, mst_rd_dev_addr=8'hA1, rd_reg=8'h22. c1_ack pulse with c1_rdata=8'h3C; no gap.
- c0 and c1 request in the same cycle, both held → grant order c0, c1, c0, c1; never two grants to one client while the other waits.
- c0 holds req one cycle past c0_ack while c1 is idle → no second grant to c0 on that cycle; mst_*_req stays 0.
- c1 requests during the GAP after a c0 write → grant exactly at GAP end; no mst req during GAP.
- I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, master never acks → mst_abort pulse at cycle 50, c0_ack with c0_err=1, c0_rdata=8'hFF. Assert reset mid-BUSY in a separate run → mst_write_req=0 next cycle and no c0_ack.
